riscv_timer: RTL and testbench

//  Memory-mapped machine timer (CLINT-style) on the core's data bus.

---
 rtl/riscv_timer.sv | 142 ++++++++++++++
 tb/tb_riscv_timer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_timer.sv
// Machine timer (CLINT-style) on the core data bus: a 64-bit mtime advanced
// by a prescaler, a 64-bit mtimecmp, and a registered level interrupt.
module riscv_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter logic        RST_EN    = 1'b0,
    parameter logic [31:0] RST_DIV   = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        I_req,
    input  logic        I_we,
    input  logic [31:0] I_addr,
    input  logic [31:0] I_wdata,
    input  logic [3:0]  I_mask,
    output logic [31:0] O_rdata,
    output logic        O_ready,
    output logic        O_hit,
    output logic        O_timer_int
);

    typedef struct packed {
        logic        req;
        logic        we;
        logic [2:0]  off;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } bus_req_t;

    localparam logic [2:0] OFF_CTRL = 3'd0;
    localparam logic [2:0] OFF_DIV  = 3'd1;
    localparam logic [2:0] OFF_MTL  = 3'd2;
    localparam logic [2:0] OFF_MTH  = 3'd3;
    localparam logic [2:0] OFF_CPL  = 3'd4;
    localparam logic [2:0] OFF_CPH  = 3'd5;

    bus_req_t    breq;
    logic        en, int_en;
    logic [31:0] div, pcnt, hi_shadow;
    logic [63:0] mtime, mtimecmp;
    logic        tick;
    logic        wr, rd;
    logic        wr_ctrl, wr_div, wr_mtl, wr_mth, wr_cpl, wr_cph;
    logic [31:0] rd_sel, wr_old, wr_new;
    logic        unused_addr_bits;

    // Byte-lane merge of write data over the current register contents.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = m[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    assign breq = '{req: I_req, we: I_we, off: I_addr[4:2], wdata: I_wdata, mask: I_mask};
    // Sub-word address bits select nothing: every access is a full word.
    assign unused_addr_bits = ^I_addr[1:0];

    assign O_hit   = (I_addr[31:5] == BASE_ADDR[31:5]);
    assign O_ready = breq.req & O_hit;
    assign wr      = breq.req & breq.we & O_hit;
    assign rd      = breq.req & ~breq.we & O_hit;

    assign wr_ctrl = wr & (breq.off == OFF_CTRL);
    assign wr_div  = wr & (breq.off == OFF_DIV);
    assign wr_mtl  = wr & (breq.off == OFF_MTL);
    assign wr_mth  = wr & (breq.off == OFF_MTH);
    assign wr_cpl  = wr & (breq.off == OFF_CPL);
    assign wr_cph  = wr & (breq.off == OFF_CPH);

    assign tick = en & (pcnt == div);

    // Register read mux and write-merge source; MTIME_HI reads the shadow
    // but a write merges into the live upper half of mtime.
    always_comb begin
        rd_sel = 32'h0;
        wr_old = 32'h0;
        case (breq.off)
            OFF_CTRL: begin rd_sel = {30'h0, int_en, en}; wr_old = rd_sel;         end
            OFF_DIV:  begin rd_sel = div;                  wr_old = div;            end
            OFF_MTL:  begin rd_sel = mtime[31:0];          wr_old = mtime[31:0];    end
            OFF_MTH:  begin rd_sel = hi_shadow;            wr_old = mtime[63:32];   end
            OFF_CPL:  begin rd_sel = mtimecmp[31:0];       wr_old = mtimecmp[31:0]; end
            OFF_CPH:  begin rd_sel = mtimecmp[63:32];      wr_old = mtimecmp[63:32]; end
            default:  begin rd_sel = 32'h0;                wr_old = 32'h0;          end
        endcase
    end

    assign wr_new  = lane_merge(wr_old, breq.wdata, breq.mask);
    assign O_rdata = (O_hit & ~breq.we) ? rd_sel : 32'h0;

    // Control and divide registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            en     <= RST_EN;
            int_en <= 1'b0;
            div    <= RST_DIV;
        end else begin
            if (wr_ctrl) {int_en, en} <= wr_new[1:0];
            if (wr_div)  div          <= wr_new;
        end
    end

    // Prescaler: restarts on any CTRL/DIV write, frozen while disabled.
    always_ff @(posedge clk) begin
        if (rst)                  pcnt <= 32'h0;
        else if (wr_ctrl | wr_div) pcnt <= 32'h0;
        else if (en)              pcnt <= tick ? 32'h0 : pcnt + 32'd1;
    end

    // mtime: a software write wins over a tick and suppresses that increment.
    always_ff @(posedge clk) begin
        if (rst)          mtime         <= 64'h0;
        else if (wr_mtl)  mtime[31:0]   <= wr_new;
        else if (wr_mth)  mtime[63:32]  <= wr_new;
        else if (tick)    mtime         <= mtime + 64'd1;
    end

    // Compare value.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (wr_cpl) mtimecmp[31:0]  <= wr_new;
            if (wr_cph) mtimecmp[63:32] <= wr_new;
        end
    end

    // Upper-half snapshot on a MTIME_LO read, so lo-then-hi reads are atomic.
    always_ff @(posedge clk) begin
        if (rst)                             hi_shadow <= 32'h0;
        else if (rd && breq.off == OFF_MTL) hi_shadow <= mtime[63:32];
    end

    // Registered level interrupt; follows the compare one cycle late.
    always_ff @(posedge clk) begin
        if (rst) O_timer_int <= 1'b0;
        else     O_timer_int <= int_en & (mtime >= mtimecmp);
    end

endmodule

// File: tb/tb_riscv_timer.sv
// Directed bench for riscv_timer: reset, prescale, interrupt, wrap/atomic
// read, byte masks, write/tick collision and address decode.
module tb_riscv_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_req, I_we;
    logic [31:0] I_addr, I_wdata;
    logic [3:0]  I_mask;
    logic [31:0] O_rdata;
    logic        O_ready, O_hit, O_timer_int;

    int checks = 0;
    int errors = 0;

    riscv_timer #(.BASE_ADDR(BASE), .RST_EN(1'b0), .RST_DIV(32'd0)) dut (
        .clk(clk), .rst(rst), .I_req(I_req), .I_we(I_we), .I_addr(I_addr),
        .I_wdata(I_wdata), .I_mask(I_mask), .O_rdata(O_rdata), .O_ready(O_ready),
        .O_hit(O_hit), .O_timer_int(O_timer_int)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_addr(input logic [2:0] off);
        return BASE + {27'd0, off, 2'b00};
    endfunction

    // One write; returns on the falling edge right after the write edge.
    task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        I_req = 1'b1; I_we = 1'b1; I_addr = reg_addr(off); I_wdata = d; I_mask = m;
        @(negedge clk);
        I_req = 1'b0; I_we = 1'b0;
    endtask

    // One read, sampled mid-cycle; the request spans one rising edge.
    task automatic rd(input logic [2:0] off, output logic [31:0] d);
        @(negedge clk);
        I_req = 1'b1; I_we = 1'b0; I_addr = reg_addr(off); I_mask = 4'h0;
        #1 d = O_rdata;
        @(negedge clk);
        I_req = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp_v [8];
        exp_v = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
        rst = 1'b1;
        // A write during reset must be discarded.
        I_req = 1'b1; I_we = 1'b1; I_addr = reg_addr(3'd4); I_wdata = 32'h0; I_mask = 4'hF;
        repeat (2) @(negedge clk);
        I_req = 1'b0; I_we = 1'b0;
        rst = 1'b0;
        checks++;
        if (O_timer_int !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", O_timer_int); end
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            checks++;
            if (v !== exp_v[i]) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", i, v, exp_v[i]); end
        end
    endtask

    task automatic test_prescale();
        logic [31:0] v, v2;
        wr(3'd1, 32'd3, 4'hF);
        wr(3'd0, 32'd1, 4'hF);
        repeat (40) @(negedge clk);
        wr(3'd0, 32'd0, 4'hF);
        rd(3'd2, v);
        checks++;
        if (v < 32'd9 || v > 32'd11) begin errors++; $display("FAIL prescale_mtime: got %0d want 10+-1", v); end
        repeat (10) @(negedge clk);
        rd(3'd2, v2);
        checks++;
        if (v2 !== v) begin errors++; $display("FAIL prescale_frozen: got %0d want %0d", v2, v); end
        rd(3'd3, v2);
        checks++;
        if (v2 !== 32'd0) begin errors++; $display("FAIL prescale_hi: got %h want 0", v2); end
    endtask

    task automatic test_interrupt();
        wr(3'd2, 32'd0, 4'hF);
        wr(3'd3, 32'd0, 4'hF);
        wr(3'd1, 32'd0, 4'hF);
        wr(3'd5, 32'd0, 4'hF);
        wr(3'd4, 32'd20, 4'hF);
        wr(3'd0, 32'd3, 4'hF);
        // One tick per edge from here: mtime = 20 after the 20th edge.
        repeat (20) @(negedge clk);
        I_req = 1'b1; I_we = 1'b0; I_addr = reg_addr(3'd2);
        #1;
        checks++;
        if (O_rdata !== 32'd20) begin errors++; $display("FAIL irq_mtime20: got %0d want 20", O_rdata); end
        checks++;
        if (O_timer_int !== 1'b0) begin errors++; $display("FAIL irq_not_yet: got %b want 0", O_timer_int); end
        @(negedge clk);
        checks++;
        if (O_timer_int !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", O_timer_int); end
        I_we = 1'b1; I_addr = reg_addr(3'd4); I_wdata = 32'd1000; I_mask = 4'hF;
        @(negedge clk);
        I_req = 1'b0; I_we = 1'b0;
        checks++;
        if (O_timer_int !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", O_timer_int); end
        @(negedge clk);
        checks++;
        if (O_timer_int !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", O_timer_int); end
        wr(3'd0, 32'd0, 4'hF);
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        wr(3'd2, 32'hFFFF_FFFE, 4'hF);
        wr(3'd3, 32'hFFFF_FFFF, 4'hF);
        wr(3'd1, 32'd0, 4'hF);
        wr(3'd0, 32'd1, 4'hF);
        @(negedge clk);
        I_req = 1'b1; I_we = 1'b0; I_addr = reg_addr(3'd2);
        #1;
        checks++;
        if (O_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_lo: got %h want ffffffff", O_rdata); end
        @(negedge clk);
        I_addr = reg_addr(3'd3);
        #1;
        checks++;
        if (O_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_hi_shadow: got %h want ffffffff", O_rdata); end
        I_req = 1'b0;
        wr(3'd0, 32'd0, 4'hF);
        rd(3'd2, v);
        checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL wrap_lo_after: got %h want 2", v); end
        rd(3'd3, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL wrap_hi_after: got %h want 0", v); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] v;
        wr(3'd4, 32'hFFFF_FFFF, 4'hF);
        wr(3'd4, 32'hAABB_CCDD, 4'b0101);
        rd(3'd4, v);
        checks++;
        if (v !== 32'hFFBB_FFDD) begin errors++; $display("FAIL mask_0101: got %h want ffbbffdd", v); end
        wr(3'd4, 32'h1234_5678, 4'b0000);
        @(negedge clk);
        I_req = 1'b1; I_we = 1'b0; I_addr = reg_addr(3'd4) | 32'h3;
        #1;
        checks++;
        if (O_rdata !== 32'hFFBB_FFDD) begin errors++; $display("FAIL mask_none_lowbits: got %h want ffbbffdd", O_rdata); end
        @(negedge clk);
        I_req = 1'b0;
    endtask

    task automatic test_collision_decode();
        logic [31:0] v;
        wr(3'd3, 32'd5, 4'hF);
        wr(3'd2, 32'd0, 4'hF);
        wr(3'd1, 32'd0, 4'hF);
        wr(3'd0, 32'd1, 4'hF);
        // Ticking every edge now; partial write of MTIME_LO on a tick edge.
        I_req = 1'b1; I_we = 1'b1; I_addr = reg_addr(3'd2); I_wdata = 32'h1122_3344; I_mask = 4'b1110;
        @(negedge clk);
        I_we = 1'b0;
        #1;
        checks++;
        if (O_rdata !== 32'h1122_3300) begin errors++; $display("FAIL collide_lo: got %h want 11223300", O_rdata); end
        @(negedge clk);
        I_addr = reg_addr(3'd3);
        #1;
        checks++;
        if (O_rdata !== 32'd5) begin errors++; $display("FAIL collide_hi: got %h want 5", O_rdata); end
        I_req = 1'b0;
        wr(3'd0, 32'd0, 4'hF);
        // Out-of-window access.
        @(negedge clk);
        I_req = 1'b1; I_we = 1'b0; I_addr = BASE + 32'h40;
        #1;
        checks++;
        if ({O_hit, O_ready, O_rdata} !== 34'h0) begin
            errors++; $display("FAIL decode_miss: got hit=%b ready=%b rdata=%h want 0 0 0", O_hit, O_ready, O_rdata);
        end
        I_we = 1'b1; I_wdata = 32'hFFFF_FFFF; I_mask = 4'hF;
        @(negedge clk);
        I_req = 1'b0; I_we = 1'b0;
        rd(3'd0, v);
        checks++;
        if (v !== 32'd0) begin errors++; $display("FAIL decode_ctrl_kept: got %h want 0", v); end
        rd(3'd4, v);
        checks++;
        if (v !== 32'hFFBB_FFDD) begin errors++; $display("FAIL decode_cmp_kept: got %h want ffbbffdd", v); end
        // Unmapped offset inside the window, and hit without a request.
        @(negedge clk);
        I_req = 1'b1; I_we = 1'b0; I_addr = reg_addr(3'd7);
        #1;
        checks++;
        if ({O_hit, O_ready, O_rdata} !== {2'b11, 32'h0}) begin
            errors++; $display("FAIL decode_unmapped: got hit=%b ready=%b rdata=%h want 1 1 0", O_hit, O_ready, O_rdata);
        end
        I_req = 1'b0;
        #1;
        checks++;
        if ({O_hit, O_ready} !== 2'b10) begin
            errors++; $display("FAIL decode_noreq: got hit=%b ready=%b want 1 0", O_hit, O_ready);
        end
    endtask

    initial begin
        rst = 1'b1; I_req = 1'b0; I_we = 1'b0; I_addr = 32'h0; I_wdata = 32'h0; I_mask = 4'h0;
        test_reset();
        test_prescale();
        test_interrupt();
        test_wrap();
        test_byte_mask();
        test_collision_decode();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
